// File: rtl/noc_local_inject_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// noc_local_inject_arbiter_pkg
// Shared constants for the local injection arbiter:
//   - Noc_Data_Width  : default flit width (kept with the other Noc_* header
//                       constants; only defined here if not already set)
//   - arb_state_t     : arbiter FSM encoding, IDLE=0, LOCKED=1
//   - NOC_ARB_MAX_FLITS : default longest legal packet (header..tail)
//   - rr_next()       : round-robin pointer advance with wrap
// Optional feature macro used by the arbiter: NOC_ARB_LEN_CHECK_EN.
// ---------------------------------------------------------------------------
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_local_inject_arbiter_pkg;

    localparam int NOC_DATA_WIDTH    = `Noc_Data_Width;
    localparam int NOC_ARB_MAX_FLITS = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index following cur, wrapping at n (n need not be a power of two).
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/noc_local_inject_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_local_inject_arbiter_if
// Bundles the requester-side and router-side flit handshakes.
//   req_valid/req_ready/req_flit/req_is_header/req_is_tail : NUM_REQ lanes,
//       lane i flit in req_flit[i*DATA_W +: DATA_W]
//   sender_valid/sender_ready/sender_flit/sender_is_header/sender_is_tail :
//       single output towards the router injection port
// Handshake rule for every channel: a transfer happens on the rising edge
// where valid && ready; the source holds data and flags stable while
// valid && !ready.
// Modports:
//   master : the environment (requesters + router) driving the arbiter
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface noc_local_inject_arbiter_if
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = NOC_DATA_WIDTH
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_is_header;
    logic [NUM_REQ-1:0]        req_is_tail;

    logic                      sender_valid;
    logic                      sender_ready;
    logic [DATA_W-1:0]         sender_flit;
    logic                      sender_is_header;
    logic                      sender_is_tail;

    modport master (
        output req_valid, req_flit, req_is_header, req_is_tail,
        input  req_ready,
        input  sender_valid, sender_flit, sender_is_header, sender_is_tail,
        output sender_ready
    );

    modport slave (
        input  req_valid, req_flit, req_is_header, req_is_tail,
        output req_ready,
        output sender_valid, sender_flit, sender_is_header, sender_is_tail,
        input  sender_ready
    );
endinterface

// File: rtl/noc_local_inject_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// noc_rr_pick
// Combinational round-robin priority picker: returns the first set bit of
// req at or after ptr, wrapping modulo N. Reusable by the router VC
// allocator.
//   req : N-bit request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot of the chosen request (all zero if none)
//   idx : index of the chosen request (0 if none)
//   any : at least one request present
// ---------------------------------------------------------------------------
module noc_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IDX_W = $clog2(N);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/noc_local_inject_arbiter.sv
// ---------------------------------------------------------------------------
// noc_local_inject_arbiter
// Packet-level round-robin arbiter sharing one NoC injection port among
// NUM_REQ local requesters. A requester is granted on a header flit and
// keeps the port until its tail flit is accepted, so packets never
// interleave. A one-flit output register sits in front of the router.
// Ports:
//   noc_clk, noc_rst : clock, asynchronous active-high reset
//   bus (slave)      : requester lanes and router sender channel
//   grant_id         : current or last owner
//   busy             : FSM is LOCKED
//   state            : FSM state (debug visibility)
//   err_len          : sticky over-length packet flag
//                      (only with NOC_ARB_LEN_CHECK_EN defined)
// Optional feature macro: NOC_ARB_LEN_CHECK_EN.
// ---------------------------------------------------------------------------
module noc_local_inject_arbiter
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = NOC_DATA_WIDTH
`ifdef NOC_ARB_LEN_CHECK_EN
  , parameter int MAX_FLITS = NOC_ARB_MAX_FLITS
`endif
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst,
    noc_local_inject_arbiter_if.slave  bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output arb_state_t                 state
`ifdef NOC_ARB_LEN_CHECK_EN
  , output logic                       err_len
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   rr_ptr_q;
    logic [NUM_REQ-1:0] grant_oh_q;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               out_free;
    logic               xfer;
    logic [DATA_W-1:0]  owner_flit;
    logic               owner_header;
    logic               owner_tail;

    // Only headers compete; stray body flits in IDLE simply stall.
    assign cand = bus.req_valid & bus.req_is_header;

    noc_rr_pick #(.N(NUM_REQ)) u_pick (
        .req (cand),
        .ptr (rr_ptr_q),
        .gnt (pick_oh),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The output register can take a flit when empty or draining this cycle.
    assign out_free     = !bus.sender_valid || bus.sender_ready;
    assign owner_flit   = bus.req_flit[int'(grant_id)*DATA_W +: DATA_W];
    assign owner_header = bus.req_is_header[grant_id];
    assign owner_tail   = bus.req_is_tail[grant_id];
    assign xfer         = (state == ARB_LOCKED) && bus.req_valid[grant_id] && out_free;
    assign busy         = (state == ARB_LOCKED);

    always_comb begin
        bus.req_ready = '0;
        if (state == ARB_LOCKED) begin
            bus.req_ready = grant_oh_q & {NUM_REQ{out_free}};
        end
    end

    // Arbitration FSM.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id   <= pick_idx;
                        grant_oh_q <= pick_oh;
                        state      <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer && owner_tail) begin
                        state    <= ARB_IDLE;
                        rr_ptr_q <= IDX_W'(rr_next(int'(grant_id), NUM_REQ));
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Output register: reload on owner transfer, otherwise drain on accept.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            bus.sender_valid     <= 1'b0;
            bus.sender_flit      <= '0;
            bus.sender_is_header <= 1'b0;
            bus.sender_is_tail   <= 1'b0;
        end else if (xfer) begin
            bus.sender_valid     <= 1'b1;
            bus.sender_flit      <= owner_flit;
            bus.sender_is_header <= owner_header;
            bus.sender_is_tail   <= owner_tail;
        end else if (bus.sender_ready) begin
            bus.sender_valid     <= 1'b0;
        end
    end

`ifdef NOC_ARB_LEN_CHECK_EN
    localparam int CNT_W = $clog2(MAX_FLITS + 2);

    logic [CNT_W-1:0] flit_cnt_q;

    // Counter saturates at MAX_FLITS+1; err_len is sticky until reset.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            flit_cnt_q <= '0;
            err_len    <= 1'b0;
        end else begin
            if (state == ARB_IDLE && pick_any) begin
                flit_cnt_q <= '0;
            end else if (xfer) begin
                if (flit_cnt_q <= CNT_W'(MAX_FLITS)) flit_cnt_q <= flit_cnt_q + 1'b1;
                if (flit_cnt_q >= CNT_W'(MAX_FLITS)) err_len <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_local_inject_arbiter
// Directed bench: per-requester flit queues feed the DUT, the expected
// router-side flit order is written by hand into exp_q, and a monitor pops
// and compares on every sender handshake.
// ---------------------------------------------------------------------------
module tb_noc_local_inject_arbiter;
    import noc_local_inject_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int FW = DW + 2;   // {is_header, is_tail, flit}

    logic       clk;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;
    arb_state_t state;
`ifdef NOC_ARB_LEN_CHECK_EN
    logic       err_len;
`endif

    noc_local_inject_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    noc_local_inject_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW)
`ifdef NOC_ARB_LEN_CHECK_EN
      , .MAX_FLITS (4)
`endif
    ) dut (
        .noc_clk  (clk),
        .noc_rst  (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .state    (state)
`ifdef NOC_ARB_LEN_CHECK_EN
      , .err_len  (err_len)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [FW-1:0] exp_q[$];
    int            acc_q[$];
    logic [FW-1:0] src_q[NR][$];
    int            start_cyc[NR];
    bit            srdy_q[$];
    int            tb_owner;
    int            n_tests;
    int            n_fail;
    int            p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int id, input int tag, input int k, input int n);
        logic [DW-1:0] f;
        f = {4'(id), 4'(tag), 8'(k)};
        return {(k == 0), (k == n - 1), f};
    endfunction

    task automatic add_src(input int id, input int n, input int tag);
        for (int k = 0; k < n; k++) src_q[id].push_back(mk(id, tag, k, n));
    endtask

    task automatic add_exp(input int id, input int n, input int tag);
        for (int k = 0; k < n; k++) exp_q.push_back(mk(id, tag, k, n));
    endtask

    // ---------------- monitor ----------------
    task automatic monitor();
        logic [FW-1:0] got;
        logic [FW-1:0] e;
        logic [FW-1:0] held;
        bit            have_held;
        have_held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_held = 1'b0;
                continue;
            end
            got = {bus.sender_is_header, bus.sender_is_tail, bus.sender_flit};
            if (have_held) begin
                check("hold_valid", 32'(bus.sender_valid), 32'd1);
                check("hold_flit", 32'(got), 32'(held));
            end
            have_held = 1'b0;
            if (bus.sender_valid && bus.sender_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got %0h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("sender_flit", 32'(got), 32'(e));
                    acc_q.push_back(cyc);
                end
            end else if (bus.sender_valid) begin
                held      = got;
                have_held = 1'b1;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus.req_valid     = '0;
        bus.req_flit      = '0;
        bus.req_is_header = '0;
        bus.req_is_tail   = '0;
        bus.sender_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        exp_q.delete();
        acc_q.delete();
        srdy_q.delete();
        for (int i = 0; i < NR; i++) begin
            src_q[i].delete();
            start_cyc[i] = 0;
        end
        tb_owner = -1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sender_valid", 32'(bus.sender_valid), 32'd0);
        check("rst_sender_flit", 32'(bus.sender_flit), 32'd0);
        check("rst_sender_flags", 32'({bus.sender_is_header, bus.sender_is_tail}), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'(ARB_IDLE));
`ifdef NOC_ARB_LEN_CHECK_EN
        check("rst_err_len", 32'(err_len), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Presents queued flits, honours start cycles and the sender_ready
    // pattern, and stops once every queue has drained.
    task automatic run_traffic(input int max_cyc);
        int            t;
        bit            empty;
        logic [FW-1:0] head;
        t = 0;
        while (1) begin
            for (int i = 0; i < NR; i++) begin
                if (t >= start_cyc[i] && src_q[i].size() > 0) begin
                    head = src_q[i][0];
                    bus.req_valid[i]         = 1'b1;
                    bus.req_is_header[i]     = head[FW-1];
                    bus.req_is_tail[i]       = head[FW-2];
                    bus.req_flit[i*DW +: DW] = head[DW-1:0];
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.sender_ready = (srdy_q.size() > 0) ? srdy_q.pop_front() : 1'b1;
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i]) begin
                    if (tb_owner >= 0 && tb_owner != i)
                        check($sformatf("ready_locked_out_r%0d", i), 32'(bus.req_ready[i]), 32'd0);
                    if (bus.req_ready[i]) begin
                        head = src_q[i].pop_front();
                        if (head[FW-1]) tb_owner = i;
                        if (head[FW-2]) tb_owner = -1;
                    end
                end
            end
            @(posedge clk);
            #1;
            t++;
            empty = (exp_q.size() == 0);
            for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) empty = 1'b0;
            if (empty) break;
            if (t >= max_cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL traffic_timeout: %0d flits still expected, required 0", exp_q.size());
                break;
            end
        end
        idle_inputs();
        for (int i = 0; i < NR; i++) start_cyc[i] = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_inputs();
        fork
            monitor();
        join_none

        do_reset();

        // Requester 0: header/data/tail with the router always ready.
        add_src(0, 3, 1);
        add_exp(0, 3, 1);
        p = cyc;
        run_traffic(100);
        check("t1_acc_count", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) begin
            check("t1_hdr_latency", 32'(acc_q[0]), 32'(p + 2));
            check("t1_body_cycle", 32'(acc_q[1]), 32'(p + 3));
            check("t1_tail_cycle", 32'(acc_q[2]), 32'(p + 4));
        end
        check("t1_grant_id", 32'(grant_id), 32'd0);
        check("t1_busy_after_tail", 32'(busy), 32'd0);

        // Four simultaneous headers with rr_ptr=0, twice.
        do_reset();
        for (int i = 0; i < NR; i++) add_src(i, 2, 2);
        for (int i = 0; i < NR; i++) add_exp(i, 2, 2);
        run_traffic(200);
        check("t3_grant_last", 32'(grant_id), 32'd3);
        for (int i = 0; i < NR; i++) add_src(i, 2, 3);
        for (int i = 0; i < NR; i++) add_exp(i, 2, 3);
        run_traffic(200);

        // Requester 2 posts a header while requester 0 is mid-packet.
        acc_q.delete();
        start_cyc[2] = 2;
        add_src(0, 4, 4);
        add_src(2, 2, 4);
        add_exp(0, 4, 4);
        add_exp(2, 2, 4);
        run_traffic(200);
        check("t4_grant_id", 32'(grant_id), 32'd2);

        // sender_ready 1,0,0,1 while the packet's flits reach the output.
        acc_q.delete();
        srdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        add_src(3, 3, 5);
        add_exp(3, 3, 5);
        p = cyc;
        run_traffic(100);
        check("t5_acc_count", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) begin
            check("t5_flit0_cycle", 32'(acc_q[0]), 32'(p + 2));
            check("t5_flit1_cycle", 32'(acc_q[1]), 32'(p + 5));
            check("t5_flit2_cycle", 32'(acc_q[2]), 32'(p + 6));
        end

        // Single-flit packet then a new header from requester 1.
        acc_q.delete();
        add_src(1, 1, 6);
        add_src(1, 2, 7);
        add_exp(1, 1, 6);
        add_exp(1, 2, 7);
        p = cyc;
        run_traffic(100);
        check("t6_acc_count", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) begin
            check("t6_single_cycle", 32'(acc_q[0]), 32'(p + 2));
            check("t6_second_hdr_cycle", 32'(acc_q[1]), 32'(p + 4));
            check("t6_second_tail_cycle", 32'(acc_q[2]), 32'(p + 5));
        end
        check("t6_grant_id", 32'(grant_id), 32'd1);

`ifdef NOC_ARB_LEN_CHECK_EN
        // MAX_FLITS=4: a 5-flit packet raises the sticky length error.
        check("t7_err_before", 32'(err_len), 32'd0);
        add_src(0, 5, 8);
        add_exp(0, 5, 8);
        run_traffic(100);
        check("t7_err_set", 32'(err_len), 32'd1);
        add_src(1, 2, 9);
        add_exp(1, 2, 9);
        run_traffic(100);
        check("t7_err_sticky", 32'(err_len), 32'd1);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
